// File: rtl/vTPU_pkg.sv
// Shared vTPU sizing constants and the enums used by the accumulator-side skew feeder.
package vTPU_pkg;

   localparam int ALPHA         = 8;
   localparam int ADD_DATAWIDTH = 32;
   localparam int Y_SCALED      = 8;

   typedef enum logic {SKEW_ASC, SKEW_DESC} skew_dir_e;

   typedef enum logic {IDLE, RUN} feeder_state_e;

endpackage

// File: rtl/acc_skew_lane.sv
// One feeder channel: decides whether its diagonal window covers step t, pops on advance,
// and registers the popped vector toward the accumulator column.
module acc_skew_lane #(
   parameter int LANES = 8,
   parameter int DW    = 32,
   parameter int TW    = 12,
   parameter int LEN_W = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TW-1:0]         t,
   input  logic [TW-1:0]         off,
   input  logic [LEN_W-1:0]      len,
   input  logic                  adv,
   input  logic [LANES*DW-1:0]   fifo_data,
   output logic                  active,
   output logic                  fifo_rd,
   output logic [LANES*DW-1:0]   acc_in,
   output logic                  acc_valid
);

   logic [TW-1:0] win_end;

   assign win_end = off + TW'(len);
   assign active  = (t >= off) && (t < win_end);
   assign fifo_rd = adv && active;

   // Anything other than a real pop drives a zero bubble into the column.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_in    <= '0;
         acc_valid <= 1'b0;
      end else if (fifo_rd) begin
         acc_in    <= fifo_data;
         acc_valid <= 1'b1;
      end else begin
         acc_in    <= '0;
         acc_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/acc_skew_feeder.sv
// Diagonal-wavefront feeder from NUM_CH show-ahead FIFOs into the accumulator column,
// with runtime length, skew direction, abort and a saturating stall counter.
module acc_skew_feeder
   import vTPU_pkg::*;
#(
   parameter  int NUM_CH  = Y_SCALED,
   parameter  int LANES   = ALPHA,
   parameter  int DW      = ADD_DATAWIDTH,
   parameter  int MAX_LEN = 256,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      len,
   input  logic                  skew_dir,
   input  logic                  abort,
   input  logic [LANES*DW-1:0]   fifo_data [NUM_CH],
   input  logic [NUM_CH-1:0]     fifo_empty,
   output logic [NUM_CH-1:0]     fifo_rd,
   output logic [LANES*DW-1:0]   acc_in [NUM_CH],
   output logic [NUM_CH-1:0]     acc_valid,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           stall_cnt
);

   localparam int TW = LEN_W + $clog2(NUM_CH);

   feeder_state_e       state;
   skew_dir_e           dir_q;
   logic [TW-1:0]       t;
   logic [LEN_W-1:0]    len_q;
   logic                done_q;
   logic [15:0]         stall_q;
   logic [NUM_CH-1:0]   active;
   logic [TW-1:0]       off [NUM_CH];
   logic                stall;
   logic                adv;
   logic                last_step;

   // A single empty FIFO inside its window freezes every channel so the diagonal stays intact.
   assign stall     = |(active & fifo_empty);
   assign adv       = (state == RUN) && !abort && !stall;
   assign last_step = (t + TW'(1)) == (TW'(len_q) + TW'(NUM_CH - 1));

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      assign off[k] = (dir_q == SKEW_DESC) ? TW'(NUM_CH - 1 - k) : TW'(k);

      acc_skew_lane #(
         .LANES (LANES),
         .DW    (DW),
         .TW    (TW),
         .LEN_W (LEN_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .t         (t),
         .off       (off[k]),
         .len       (len_q),
         .adv       (adv),
         .fifo_data (fifo_data[k]),
         .active    (active[k]),
         .fifo_rd   (fifo_rd[k]),
         .acc_in    (acc_in[k]),
         .acc_valid (acc_valid[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dir_q   <= SKEW_ASC;
         t       <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q   <= len;
                  dir_q   <= skew_dir_e'(skew_dir);
                  t       <= '0;
                  stall_q <= '0;
                  // A zero-length pass completes without ever entering RUN.
                  if (len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end else if (stall) begin
                  if (stall_q != 16'hFFFF) begin
                     stall_q <= stall_q + 16'd1;
                  end
               end else begin
                  t <= t + TW'(1);
                  if (last_step) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == RUN);
   assign done      = done_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_acc_skew_feeder.sv
// Directed scoreboard bench for acc_skew_feeder with four 2x8-bit channels and modelled
// show-ahead FIFOs; expected pops and outputs are derived from the wavefront schedule.
module tb_acc_skew_feeder;

   localparam int NCH     = 4;
   localparam int LANES   = 2;
   localparam int DW      = 8;
   localparam int MAX_LEN = 256;
   localparam int LEN_W   = 9;
   localparam int VW      = LANES * DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              skew_dir = 1'b0;
   logic              abort = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic [VW-1:0]     fifo_data [NCH];
   logic [NCH-1:0]    fifo_empty;
   logic [NCH-1:0]    fifo_rd;
   logic [VW-1:0]     acc_in [NCH];
   logic [NCH-1:0]    acc_valid;
   logic              busy;
   logic              done;
   logic [15:0]       stall_cnt;

   typedef struct { int cyc; logic [VW-1:0] data; } exp_t;
   typedef struct { int ch; logic [VW-1:0] data; } push_t;

   exp_t            out_q [NCH][$];
   int              rd_q  [NCH][$];
   logic [VW-1:0]   fq    [NCH][$];
   push_t           pend [$];
   int              base_idx [NCH];
   logic [NCH-1:0]  rd_snap;
   int              cyc;
   int              checks = 0;
   int              errors = 0;
   int              exp_done;
   int              busy_to;
   int              exp_stall;

   acc_skew_feeder #(
      .NUM_CH  (NCH),
      .LANES   (LANES),
      .DW      (DW),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .skew_dir   (skew_dir),
      .abort      (abort),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .acc_in     (acc_in),
      .acc_valid  (acc_valid),
      .busy       (busy),
      .done       (done),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] word(input int k, input int p, input int i);
      return VW'((k + 1) * 4096 + p * 256 + i + 1);
   endfunction

   // FIFO model: pop strobes are snapshotted mid-cycle, applied just after the edge.
   initial begin
      push_t p;
      for (int k = 0; k < NCH; k++) begin
         fifo_empty[k] = 1'b1;
         fifo_data[k]  = '0;
      end
      forever begin
         @(negedge clk);
         #3;
         rd_snap = fifo_rd;
         @(posedge clk);
         #1;
         for (int k = 0; k < NCH; k++) begin
            if (rd_snap[k] && fq[k].size() > 0) void'(fq[k].pop_front());
         end
         while (pend.size() > 0) begin
            p = pend.pop_front();
            if (p.ch < 0) begin
               for (int k = 0; k < NCH; k++) fq[k].delete();
            end else begin
               fq[p.ch].push_back(p.data);
            end
         end
         for (int k = 0; k < NCH; k++) begin
            fifo_empty[k] = (fq[k].size() == 0);
            fifo_data[k]  = (fq[k].size() == 0) ? '0 : fq[k][0];
         end
      end
   end

   task automatic flushFifos();
      push_t p;
      p.ch = -1;
      p.data = '0;
      pend.push_back(p);
   endtask

   task automatic fillFifo(input int k, input int count, input int pass);
      push_t p;
      for (int i = 0; i < count; i++) begin
         p.ch = k;
         p.data = word(k, pass, i);
         pend.push_back(p);
      end
   endtask

   // Registered outputs, checked at the falling edge against the scoreboard.
   task automatic checkOutput();
      logic          ev;
      logic [VW-1:0] ed;
      for (int k = 0; k < NCH; k++) begin
         while (out_q[k].size() > 0 && out_q[k][0].cyc < cyc) void'(out_q[k].pop_front());
         ev = (out_q[k].size() > 0) && (out_q[k][0].cyc == cyc);
         ed = ev ? out_q[k][0].data : '0;
         checks++;
         assert (acc_valid[k] === ev) else begin
            errors++;
            $error("[TB] FAIL acc_valid ch%0d cyc%0d: observed=%b expected=%b", k, cyc, acc_valid[k], ev);
         end
         checks++;
         assert (acc_in[k] === ed) else begin
            errors++;
            $error("[TB] FAIL acc_in ch%0d cyc%0d: observed=%h expected=%h", k, cyc, acc_in[k], ed);
         end
         if (ev) void'(out_q[k].pop_front());
      end
      checks++;
      assert (busy === (cyc >= 1 && cyc <= busy_to)) else begin
         errors++;
         $error("[TB] FAIL busy cyc%0d: observed=%b expected=%b", cyc, busy, (cyc >= 1 && cyc <= busy_to));
      end
      checks++;
      assert (done === (cyc == exp_done)) else begin
         errors++;
         $error("[TB] FAIL done cyc%0d: observed=%b expected=%b", cyc, done, (cyc == exp_done));
      end
      if (cyc == exp_done) begin
         checks++;
         assert (stall_cnt === 16'(exp_stall)) else begin
            errors++;
            $error("[TB] FAIL stall_cnt cyc%0d: observed=%0d expected=%0d", cyc, stall_cnt, exp_stall);
         end
      end
   endtask

   // Pop strobes are combinational, so they are checked after this cycle's inputs settle.
   task automatic checkPops();
      logic er;
      for (int k = 0; k < NCH; k++) begin
         while (rd_q[k].size() > 0 && rd_q[k][0] < cyc) void'(rd_q[k].pop_front());
         er = (rd_q[k].size() > 0) && (rd_q[k][0] == cyc);
         checks++;
         assert (fifo_rd[k] === er) else begin
            errors++;
            $error("[TB] FAIL fifo_rd ch%0d cyc%0d: observed=%b expected=%b", k, cyc, fifo_rd[k], er);
         end
         if (er) void'(rd_q[k].pop_front());
      end
   endtask

   task automatic step();
      #1;
      checkPops();
      @(negedge clk);
      cyc++;
      checkOutput();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Drives start for cycle 0 and schedules the expected wavefront: step s pops in cycle
   // 1+s (plus any stall cycles before it) and shows up on acc_in one cycle later.
   task automatic applyStimulus(input int n, input logic dir, input int stall_step,
                                input int stall_len, input int rd_until, input int out_until,
                                input int pass);
      int   off;
      int   s;
      int   pc;
      exp_t e;
      start    = 1'b1;
      len      = LEN_W'(n);
      skew_dir = dir;
      cyc      = 0;
      for (int k = 0; k < NCH; k++) begin
         out_q[k].delete();
         rd_q[k].delete();
         off = dir ? (NCH - 1 - k) : k;
         for (int i = 0; i < n; i++) begin
            s  = off + i;
            pc = 1 + s + ((stall_len > 0 && s >= stall_step) ? stall_len : 0);
            if (pc <= rd_until) rd_q[k].push_back(pc);
            if (pc + 1 <= out_until) begin
               e.cyc  = pc + 1;
               e.data = word(k, pass, base_idx[k] + i);
               out_q[k].push_back(e);
            end
         end
      end
      exp_stall = stall_len;
      if (n == 0) begin
         exp_done = 1;
         busy_to  = 0;
      end else begin
         exp_done = n + NCH + stall_len;
         busy_to  = exp_done - 1;
      end
   endtask

   initial begin
      int consumed;
      exp_done  = -1;
      busy_to   = 0;
      exp_stall = 0;
      cyc       = 50;
      for (int k = 0; k < NCH; k++) base_idx[k] = 0;

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      checkOutput();
      rst = 1'b0;

      $display("[TB] basic ascending");
      flushFifos();
      for (int k = 0; k < NCH; k++) fillFifo(k, 3, 1);
      step();
      applyStimulus(3, 1'b0, 0, 0, 1000, 1000, 1);
      step();
      start = 1'b0;
      runCycles(9);

      $display("[TB] descending");
      flushFifos();
      for (int k = 0; k < NCH; k++) fillFifo(k, 3, 2);
      step();
      applyStimulus(3, 1'b1, 0, 0, 1000, 1000, 2);
      step();
      start = 1'b0;
      runCycles(9);

      $display("[TB] stall on channel 2");
      flushFifos();
      fillFifo(0, 3, 3);
      fillFifo(1, 3, 3);
      fillFifo(3, 3, 3);
      step();
      applyStimulus(3, 1'b0, 2, 2, 1000, 1000, 3);
      step();
      start = 1'b0;
      runCycles(3);
      fillFifo(2, 3, 3);
      runCycles(8);

      $display("[TB] zero length");
      flushFifos();
      for (int k = 0; k < NCH; k++) fillFifo(k, 2, 4);
      step();
      applyStimulus(0, 1'b0, 0, 0, 1000, 1000, 4);
      step();
      start = 1'b0;
      runCycles(4);

      $display("[TB] abort and restart");
      flushFifos();
      for (int k = 0; k < NCH; k++) fillFifo(k, 5, 5);
      step();
      applyStimulus(5, 1'b0, 0, 0, 3, 4, 5);
      exp_done = 5;
      busy_to  = 4;
      step();
      start = 1'b0;
      runCycles(3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         consumed = 0;
         for (int s = 0; s < 3; s++) if (s >= k && s < k + 5) consumed++;
         base_idx[k] = consumed;
         checks++;
         assert (fq[k].size() === 5 - consumed) else begin
            errors++;
            $error("[TB] FAIL fifo_left ch%0d: observed=%0d expected=%0d", k, fq[k].size(), 5 - consumed);
         end
         if (fq[k].size() > 0) begin
            checks++;
            assert (fq[k][0] === word(k, 5, consumed)) else begin
               errors++;
               $error("[TB] FAIL fifo_head ch%0d: observed=%h expected=%h", k, fq[k][0], word(k, 5, consumed));
            end
         end
      end
      applyStimulus(2, 1'b0, 0, 0, 1000, 1000, 5);
      step();
      start = 1'b0;
      runCycles(7);
      for (int k = 0; k < NCH; k++) base_idx[k] = 0;

      $display("[TB] reset mid-pass");
      flushFifos();
      for (int k = 0; k < NCH; k++) fillFifo(k, 3, 6);
      step();
      applyStimulus(3, 1'b0, 0, 0, 3, 3, 6);
      exp_done = -1;
      busy_to  = 3;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      rst   = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      assert (stall_cnt === 16'd0) else begin
         errors++;
         $error("[TB] FAIL stall_cnt_after_rst: observed=%0d expected=0", stall_cnt);
      end
      runCycles(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
